ser_feeder: RTL
===============

# ser_feeder

Upstream stage of the serial pattern detector. Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. Shifts each word out one bit per clock on `ser_out`, which drives the detector's `ser_in`. Consecutive words stream with no gap between them; the line sits at a fixed idle level when no data is queued.

## Interface
- `WIDTH`, 8, bits per word (≥2)
- `DEPTH`, 4, FIFO entries (power of 2, ≥2)
- `IDLE_BIT`, 1'b0, level driven on `ser_out` when not shifting
- `clock`  input  1  single clock, all state on rising edge
- `rst_n`  input  1  reset, asynchronous, active-low
- `data_in`  input  WIDTH  word to serialize
- `data_valid`  input  1  `data_in` is offered
- `data_ready`  output  1  FIFO can accept a word this cycle
- `msb_first`  input  1  bit order, sampled when a word enters the shift register
- `ser_out`  output  1  serial bit stream (registered)
- `ser_valid`  output  1  `ser_out` carries a data bit (high in SHIFT)
- `word_done`  output  1  one-cycle pulse during the last bit of each word
- `stream_end`  output  1  one-cycle pulse on the first idle cycle after SHIFT
- `busy`  output  1  SHIFT state or FIFO non-empty

## Operation
- Reset state: FIFO empty; state IDLE; `ser_out`=IDLE_BIT; `ser_valid`=0; `word_done`=0; `stream_end`=0; `busy`=0; `data_ready`=1.
- Push: the FIFO stores `data_in` on any edge where `data_valid && data_ready`.
- `data_ready` = !full. There is no bypass. When the FIFO is full, a push is refused even if a pop occurs on the same edge.
- FSM, two states:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, latch `msb_first`, load bit counter=WIDTH-1, go to SHIFT. Otherwise hold.
  - SHIFT: present the current bit and decrement the counter each edge. At counter==0 (last bit):
    - If the FIFO is non-empty, pop and reload on that same edge and stay in SHIFT. No gap.
    - Else go to IDLE.
- Bit order:
  - msb_first=1 sends bit WIDTH-1 first.
  - msb_first=0 sends bit 0 first.
  - A change to `msb_first` mid-word has no effect until the next load.
- The FIFO uses a pointer-wrap full/empty scheme with an extra MSB on each pointer. Wrap-around past DEPTH-1 must be seamless.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.
- Reset asserted mid-word: all outputs return to reset values immediately (asynchronous). Queued words are discarded, and no `word_done` or `stream_end` pulse is generated.

## Timing
- Minimum latency, word accepted at edge k into an empty, idle block:
  - Popped at edge k+1.
  - First bit on `ser_out` from edge k+1 to edge k+2.
  - Last bit from edge k+WIDTH to edge k+WIDTH+1.
- Each bit is held exactly one clock, so the detector samples it once.
- `word_done` is high during the same cycle as the last bit of the word.
- `stream_end` is high in the first cycle after the last bit when no reload occurred. In that cycle `ser_out`=IDLE_BIT and `ser_valid`=0.
- Sustained throughput: one word per WIDTH clocks with `data_valid` held high.
- `ser_out`, `ser_valid`, `word_done` and `stream_end` are all registered. `data_ready` and `busy` are combinational from registered state only.

## Structure
- Shared package `ser_pkg` holds:
  - State encoding localparams `S_IDLE`=1'b0 and `S_SHIFT`=1'b1.
  - Default `WIDTH` and `DEPTH` constants used by both this block and the detector bench.
- Sub-module `ser_fifo`: synchronous FIFO, parameterized by WIDTH/DEPTH, with ports push/pop/din/dout/full/empty.
- The top level contains the FSM, shift register and bit counter.

## Test plan
- Reset, then push 8'hA5 with msb_first=1 -> `ser_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after acceptance. `word_done` is high on the 8th bit, and `stream_end` on the next cycle.
- Push 8'h1D with msb_first=0 -> `ser_out` = 1,0,1,1,1,0,0,0. Toggling `msb_first` mid-word does not alter the sequence.
- Hold `data_valid`=1 and push 6 words -> `data_ready` drops once DEPTH=4 words are queued. 48 contiguous bits are sent with `ser_valid` never low, 6 `word_done` pulses occur and one `stream_end` follows.
- Push while full on an edge where a pop occurs -> the word is not accepted. The source must hold it until the next edge with `data_ready`=1, and no word is lost or duplicated.
- Assert `rst_n`=0 at the 3rd bit of a word with 2 more queued -> outputs are at reset values immediately. After release no stale bits are emitted, and `busy`=0.
- Integration: `ser_out` drives the detector with pattern 4'b1010 and overlap=1. Push 8'hAA msb_first=1 -> the detector's `found` pulses 3 times, on bits 4, 6 and 8.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the serial feeder and the serial pattern detector.
package ser_pkg;

    // Default word width and FIFO depth.
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // State encoding of the feeder FSM.
    localparam logic S_IDLE  = 1'b0;
    localparam logic S_SHIFT = 1'b1;

    typedef enum logic {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT
    } feeder_state_e;

endpackage

// File: rtl/ser_fifo.sv
// Synchronous FIFO using extra-MSB pointers to tell full from empty.
// A push while full or a pop while empty is ignored.
module ser_fifo
    import ser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Same index with different wrap bits means the write pointer lapped the read pointer.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ser_feeder.sv
// Parallel-to-serial feeder: buffers words in a FIFO and shifts them out
// one bit per clock, back-to-back, idling at IDLE_BIT when nothing is queued.
//
// Handshake: a word transfers on every rising edge where data_valid and
// data_ready are both high; data_ready depends only on registered state
// (FIFO not full), so the source may hold data_valid high and simply wait.
module ser_feeder
    import ser_pkg::*;
#(
    parameter int   WIDTH    = DEFAULT_WIDTH,
    parameter int   DEPTH    = DEFAULT_DEPTH,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             msb_first,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             stream_end,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    feeder_state_e    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             msb_q, msb_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;
    logic             stream_end_q, stream_end_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             load;

    ser_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (data_valid),
        .pop   (fifo_pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // No bypass: a full FIFO refuses a push even on an edge that pops.
    assign data_ready = !fifo_full;
    assign busy       = (state_q == ST_SHIFT) || !fifo_empty;

    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign word_done  = word_done_q;
    assign stream_end = stream_end_q;

    // Next state: load a word from IDLE or on the last bit, otherwise shift or go idle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sreg_d       = sreg_q;
        msb_d        = msb_q;
        ser_out_d    = ser_out_q;
        ser_valid_d  = ser_valid_q;
        word_done_d  = 1'b0;
        stream_end_d = 1'b0;
        load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ser_out_d   = IDLE_BIT;
                ser_valid_d = 1'b0;
                if (!fifo_empty) load = 1'b1;
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d      = ST_IDLE;
                        ser_out_d    = IDLE_BIT;
                        ser_valid_d  = 1'b0;
                        stream_end_d = 1'b1;
                    end
                end else begin
                    ser_out_d   = msb_q ? sreg_q[WIDTH-1] : sreg_q[0];
                    sreg_d      = msb_q ? (sreg_q << 1) : (sreg_q >> 1);
                    cnt_d       = cnt_q - CW'(1);
                    word_done_d = (cnt_q == CW'(1));
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The first bit goes straight to ser_out; the rest wait in sreg.
        if (load) begin
            state_d     = ST_SHIFT;
            msb_d       = msb_first;
            ser_out_d   = msb_first ? fifo_dout[WIDTH-1] : fifo_dout[0];
            sreg_d      = msb_first ? (fifo_dout << 1) : (fifo_dout >> 1);
            cnt_d       = CW'(WIDTH - 1);
            ser_valid_d = 1'b1;
        end
    end

    assign fifo_pop = load;

    // State, shifter and registered serial outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            msb_q        <= 1'b0;
            ser_out_q    <= IDLE_BIT;
            ser_valid_q  <= 1'b0;
            word_done_q  <= 1'b0;
            stream_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            msb_q        <= msb_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            word_done_q  <= word_done_d;
            stream_end_q <= stream_end_d;
        end
    end

endmodule
